// File: rtl/wptr_full.sv
// wptr_full: write-side pointer logic of an async FIFO.
// Tracks full/almost-full, a pessimistic fill level and a sticky overflow flag.
module wptr_full #(
  parameter int A_Size   = 9,
  parameter int AF_Level = 2**A_Size-4
) (
  input  logic            w_clk,
  input  logic            w_rst,
  input  logic            w_inc,
  input  logic [A_Size:0] rptr_sync,
  output logic [A_Size:0] waddr,
  output logic [A_Size:0] wptr,
  output logic            w_en,
  output logic            wfull,
  output logic            walmost_full,
  output logic [A_Size:0] wlevel,
  output logic            wovf
);
  localparam logic [A_Size:0] AF = (A_Size+1)'(AF_Level);
  logic [A_Size:0] next_waddr, next_wptr, next_level, rbin;
  for (genvar g = 0; g <= A_Size; g++) begin : g_rbin
    assign rbin[g] = ^(rptr_sync >> g);
  end
  assign w_en       = w_inc & ~wfull;
  assign next_waddr = waddr + {{A_Size{1'b0}}, w_en};
  assign next_wptr  = (next_waddr >> 1) ^ next_waddr;
  assign next_level = next_waddr - rbin;
  always_ff @(posedge w_clk)
    if (w_rst) begin
      waddr        <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      wovf         <= 1'b0;
    end else begin
      waddr        <= next_waddr;
      wptr         <= next_wptr;
      wfull        <= next_wptr == {~rptr_sync[A_Size:A_Size-1], rptr_sync[A_Size-2:0]};
      walmost_full <= next_level >= AF;
      wlevel       <= next_level;
      wovf         <= wovf | (w_inc & wfull);
    end
endmodule

// File: tb/tb_wptr_full.sv
// tb_wptr_full: vector table, directed corner sequences and random traffic vs an occupancy model.
module tb_wptr_full;
  localparam int A  = 9;
  localparam int AW = A+1;
  localparam int D  = 2**A;
  localparam int AFL = D-4;
  logic w_clk = 0, w_rst = 1, w_inc = 0;
  logic [A:0] rptr_sync = '0;
  logic [A:0] waddr, wptr, wlevel;
  logic w_en, wfull, walmost_full, wovf;
  int total = 0, bad = 0;
  int wr = 0, rd = 0;
  bit m_full = 0, m_ovf = 0, saw_full = 0;
  wptr_full #(.A_Size(A), .AF_Level(AFL)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_inc(w_inc), .rptr_sync(rptr_sync),
    .waddr(waddr), .wptr(wptr), .w_en(w_en), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .wovf(wovf)
  );
  always #5 w_clk = ~w_clk;
  function automatic int gray(input int b);
    return (b % (2*D)) ^ ((b % (2*D)) >> 1);
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", n, act, exp, $time);
    end
  endtask
  // One write-domain cycle; rdn is the total number of reads visible this cycle.
  task automatic cyc(input bit inc, input int rdn);
    bit acc;
    w_inc = inc;
    rptr_sync = AW'(gray(rdn));
    #1;
    chk("w_en", int'(w_en), int'(inc && !m_full));
    acc = inc && !m_full;
    m_ovf = m_ovf | (inc && m_full);
    wr = wr + int'(acc);
    rd = rdn;
    m_full = (wr - rd) == D;
    if (m_full) saw_full = 1;
    @(posedge w_clk); #1;
    chk("waddr", int'(waddr), wr % (2*D));
    chk("wptr", int'(wptr), gray(wr));
    chk("wfull", int'(wfull), int'(m_full));
    chk("walmost_full", int'(walmost_full), int'((wr - rd) >= AFL));
    chk("wlevel", int'(wlevel), wr - rd);
    chk("wovf", int'(wovf), int'(m_ovf));
  endtask
  task automatic do_reset();
    w_rst = 1; w_inc = 0; rptr_sync = '0;
    repeat (2) @(posedge w_clk);
    #1;
    w_rst = 0;
    wr = 0; rd = 0; m_full = 0; m_ovf = 0;
  endtask
  typedef struct {
    bit rst; bit inc; int rd;
    int en; int wa; int wp; int full; int af; int lvl; int ovf;
  } vec_t;
  vec_t vt[11];
  initial begin
    vt[0]  = '{1,1,0, 1,0,0,0,0,0,0};
    vt[1]  = '{1,1,0, 1,0,0,0,0,0,0};
    vt[2]  = '{1,1,0, 1,0,0,0,0,0,0};
    vt[3]  = '{0,1,0, 1,1,1,0,0,1,0};
    vt[4]  = '{0,1,0, 1,2,3,0,0,2,0};
    vt[5]  = '{0,0,0, 0,2,3,0,0,2,0};
    vt[6]  = '{0,1,1, 1,3,2,0,0,2,0};
    vt[7]  = '{0,1,3, 1,4,6,0,0,1,0};
    vt[8]  = '{0,0,4, 0,4,6,0,0,0,0};
    vt[9]  = '{0,1,4, 1,5,7,0,0,1,0};
    vt[10] = '{1,1,4, 1,0,0,0,0,0,0};
    w_rst = 1; w_inc = 0;
    @(posedge w_clk); #1;
    foreach (vt[i]) begin
      w_rst = vt[i].rst; w_inc = vt[i].inc; rptr_sync = AW'(gray(vt[i].rd));
      #1;
      chk("tbl_w_en", int'(w_en), vt[i].en);
      @(posedge w_clk); #1;
      chk("tbl_waddr", int'(waddr), vt[i].wa);
      chk("tbl_wptr", int'(wptr), vt[i].wp);
      chk("tbl_wfull", int'(wfull), vt[i].full);
      chk("tbl_af", int'(walmost_full), vt[i].af);
      chk("tbl_wlevel", int'(wlevel), vt[i].lvl);
      chk("tbl_wovf", int'(wovf), vt[i].ovf);
    end
    // Fill from empty with the reader stalled.
    do_reset();
    for (int i = 1; i <= D; i++) begin
      cyc(1, 0);
      if (i == AFL-1) chk("fill_af_below", int'(walmost_full), 0);
      if (i == AFL) begin
        chk("fill_af_at", int'(walmost_full), 1);
        chk("fill_lvl_at", int'(wlevel), AFL);
      end
      if (i == D-1) chk("fill_not_full", int'(wfull), 0);
    end
    chk("full_flag", int'(wfull), 1);
    chk("full_waddr", int'(waddr), 'h200);
    chk("full_wptr", int'(wptr), 'h300);
    chk("full_lvl", int'(wlevel), D);
    // Overflow attempt while full.
    cyc(1, 0);
    chk("ovf_waddr", int'(waddr), 'h200);
    chk("ovf_set", int'(wovf), 1);
    cyc(0, 0);
    chk("ovf_sticky", int'(wovf), 1);
    // Release by one read.
    cyc(0, 1);
    chk("rel_full", int'(wfull), 0);
    chk("rel_lvl", int'(wlevel), D-1);
    chk("rel_af", int'(walmost_full), 1);
    chk("rel_ovf_held", int'(wovf), 1);
    // Write and read in the same cycle at level 511.
    cyc(1, 2);
    chk("sim_lvl", int'(wlevel), D-1);
    chk("sim_full", int'(wfull), 0);
    do_reset();
    #1;
    chk("rst_ovf_clear", int'(wovf), 0);
    // Wrap: reader trails the writer by four entries.
    saw_full = 0;
    for (int i = 1; i <= 2*D; i++) begin
      cyc(1, (i > 4) ? i-4 : 0);
      if (i == 2*D-1) begin
        chk("wrap_pre_waddr", int'(waddr), 'h3FF);
        chk("wrap_pre_wptr", int'(wptr), 'h200);
      end
    end
    chk("wrap_waddr", int'(waddr), 0);
    chk("wrap_wptr", int'(wptr), 0);
    chk("wrap_lvl", int'(wlevel), 4);
    chk("wrap_never_full", int'(saw_full), 0);
    // Random traffic, write-heavy so full and overflow are reached.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int rn;
      rn = rd;
      if (($urandom % 3 == 0) && rn < wr) rn = rn + 1 + int'($urandom % 2);
      if (rn > wr) rn = wr;
      cyc(($urandom % 4) != 0, rn);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 SHALL have parameter A_Size, default 9, memory address width; depth = 2**A_Size; pointers are A_Size+1 bits.
REQ-002 SHALL have parameter AF_Level, default 2**A_Size-4, fill level at and above which walmost_full asserts; legal range 1..2**A_Size.
REQ-003 SHALL have port w_clk, input, 1, write-domain clock; the block has only this one clock.
REQ-004 SHALL have port w_rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port w_inc, input, 1, write request from the producer.
REQ-006 SHALL have port rptr_sync, input, A_Size+1, Gray read pointer, already synchronized into w_clk.
REQ-007 SHALL have port waddr, output, A_Size+1, registered binary write pointer; bits [A_Size-1:0] address the memory.
REQ-008 SHALL have port wptr, output, A_Size+1, registered Gray write pointer, sent to the read-domain synchronizer.
REQ-009 SHALL have port w_en, output, 1, combinational memory write enable = w_inc & !wfull.
REQ-010 SHALL have port wfull, output, 1, registered full flag.
REQ-011 SHALL have port walmost_full, output, 1, registered almost-full flag.
REQ-012 SHALL have port wlevel, output, A_Size+1, registered conservative fill count, 0..2**A_Size.
REQ-013 SHALL have port wovf, output, 1, sticky overflow error flag.

Function
REQ-014 SHALL compute next_waddr = waddr + w_en, modulo 2**(A_Size+1), wrapping silently.
REQ-015 SHALL compute next_wptr = (next_waddr >> 1) ^ next_waddr.
REQ-016 SHALL register waddr <= next_waddr and wptr <= next_wptr on every w_clk edge; one cycle latency from accepted w_inc.
REQ-017 SHALL register wfull <= (next_wptr == {~rptr_sync[A_Size:A_Size-1], rptr_sync[A_Size-2:0]}).
REQ-018 SHALL make wfull assert on the same edge that accepts the 2**A_Size-th outstanding write (no extra cycle).
REQ-019 SHALL deassert wfull on the first edge after rptr_sync advances, even when w_inc is held high.
REQ-020 SHALL convert rptr_sync to binary rbin by prefix XOR from the MSB down, in combinational logic.
REQ-021 SHALL compute next_level = next_waddr - rbin, modulo 2**(A_Size+1); wlevel <= next_level.
REQ-022 SHALL register walmost_full <= (next_level >= AF_Level).
REQ-023 SHALL treat w_inc while wfull=1 as an overflow: no pointer change, w_en=0, memory untouched.
REQ-024 SHALL set wovf on the edge following an overflow cycle; wovf stays high until reset.
REQ-025 SHALL let wfull, walmost_full and wlevel lag true read progress by the synchronizer delay, making them pessimistic and never optimistic.
REQ-026 SHALL evaluate read pointer movement and a write in the same cycle together: the new level reflects both.

Reset
REQ-027 SHALL, while w_rst=1 at a w_clk edge, load waddr=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, wovf=0.
REQ-028 SHALL, on reset asserted mid-operation, override the in-flight write; w_en remains w_inc & !wfull during that cycle.
REQ-029 SHALL treat rptr_sync during reset as don't-care; flags re-evaluate from the first post-reset edge.

Verification (defaults A_Size=9, AF_Level=508)
REQ-030 SHALL cover reset: hold w_rst=1 with w_inc=1 for 3 clocks -> all outputs 0, waddr stays 0.
REQ-031 SHALL cover fill: rptr_sync=0, w_inc=1 for 512 clocks -> walmost_full=1 after write 508 (wlevel=508); after write 512, wfull=1, waddr=10'h200, wptr=10'h300, wlevel=512.
REQ-032 SHALL cover overflow: from full, w_inc=1 one more clock -> w_en=0, waddr unchanged at 10'h200, wovf=1 next edge and held until w_rst.
REQ-033 SHALL cover release: at full, rptr_sync 0->10'h001 with w_inc=0 -> wfull=0 and wlevel=511 next edge; walmost_full stays 1.
REQ-034 SHALL cover wrap: 1024 total writes with rptr_sync tracking gray(waddr-4) -> waddr wraps 10'h3FF->10'h000, wptr 10'h200->10'h000, wlevel=4, wfull never set.
REQ-035 SHALL cover simultaneous events: at wlevel=511, w_inc=1 and rptr_sync advances by 1 in the same cycle -> wlevel=511, wfull=0.
